// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_pipe
// Brief    : ID decode, EX/MEM/WB control pipeline, mul/div sequencer and
//            hazard unit. Macro CONTROL_PIPE_BYPASS_EN enables forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module control_pipe #(
    parameter int OP_W   = 5,
    parameter int FUNC_W = 5,
    parameter int REG_W  = 5,
    parameter int MD_LAT = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [FUNC_W-1:0] id_func,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    output logic              stall,
    output logic              illegal,
    output logic              ex_rwe,
    output logic              ex_rdst,
    output logic              ex_aluinb,
    output logic              ex_dmwe,
    output logic              ex_rwd,
    output logic [FUNC_W-1:0] ex_aluop,
    output logic              ex_md_busy,
    output logic              ex_md_done,
    output logic              mem_dmwe,
    output logic              mem_rwd,
    output logic              wb_rwe,
    output logic              wb_rwd,
    output logic [REG_W-1:0]  wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam int CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;

    localparam logic [OP_W-1:0]   c_op_rtype = OP_W'(0);
    localparam logic [OP_W-1:0]   c_op_addi  = OP_W'(5);
    localparam logic [OP_W-1:0]   c_op_sw    = OP_W'(7);
    localparam logic [OP_W-1:0]   c_op_lw    = OP_W'(8);
    localparam logic [FUNC_W-1:0] c_fn_mul   = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] c_fn_div   = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] c_fn_last  = FUNC_W'(7);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic              w_dec_rwe, w_dec_rdst, w_dec_aluinb, w_dec_dmwe, w_dec_rwd;
    logic              w_dec_md, w_dec_legal;
    logic [FUNC_W-1:0] w_dec_aluop;
    logic              w_id_live, w_id_md;
    logic              w_md_stall, w_hz_stall, w_lu_hit;
    logic              w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;

    logic              r_ex_rwe, r_ex_rdst, r_ex_aluinb, r_ex_dmwe, r_ex_rwd;
    logic [FUNC_W-1:0] r_ex_aluop;
    logic [REG_W-1:0]  r_ex_rd;
    logic              r_mem_rwe, r_mem_dmwe, r_mem_rwd;
    logic [REG_W-1:0]  r_mem_rd;
    logic              r_wb_rwe, r_wb_rwd;
    logic [REG_W-1:0]  r_wb_rd;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_md_busy, r_md_done;

    always_comb begin
        w_dec_rwe    = 1'b0;
        w_dec_rdst   = 1'b0;
        w_dec_aluinb = 1'b0;
        w_dec_dmwe   = 1'b0;
        w_dec_rwd    = 1'b0;
        w_dec_aluop  = '0;
        w_dec_md     = 1'b0;
        w_dec_legal  = 1'b1;
        case (id_opcode)
            c_op_rtype: begin
                if (id_func <= c_fn_last) begin
                    w_dec_rwe   = 1'b1;
                    w_dec_aluop = id_func;
                    w_dec_md    = (id_func == c_fn_mul) || (id_func == c_fn_div);
                end else begin
                    w_dec_legal = 1'b0;
                end
            end
            c_op_addi: begin
                w_dec_rwe    = 1'b1;
                w_dec_aluinb = 1'b1;
            end
            c_op_sw: begin
                w_dec_dmwe   = 1'b1;
                w_dec_rdst   = 1'b1;
                w_dec_aluinb = 1'b1;
            end
            c_op_lw: begin
                w_dec_rwe    = 1'b1;
                w_dec_rwd    = 1'b1;
                w_dec_aluinb = 1'b1;
            end
            default: w_dec_legal = 1'b0;
        endcase
    end

    assign w_id_live = id_valid && w_dec_legal;
    assign w_id_md   = w_id_live && w_dec_md;
    // Gated so the combinational flag also reads 0 while reset is asserted.
    assign illegal   = resetn && id_valid && !w_dec_legal;

    // Stage rwe is only ever set with a nonzero rd, so rwe alone qualifies a writer.
    assign w_ex_hit_a  = r_ex_rwe  && (r_ex_rd  == id_rs);
    assign w_ex_hit_b  = r_ex_rwe  && (r_ex_rd  == id_rt);
    assign w_mem_hit_a = r_mem_rwe && (r_mem_rd == id_rs);
    assign w_mem_hit_b = r_mem_rwe && (r_mem_rd == id_rt);
    assign w_lu_hit    = r_ex_rwd && (r_ex_rd != '0) &&
                         ((r_ex_rd == id_rs) || (r_ex_rd == id_rt));

`ifdef CONTROL_PIPE_BYPASS_EN
    assign w_hz_stall = id_valid && w_lu_hit;
    assign fwd_a = w_ex_hit_a ? 2'b01 : (w_mem_hit_a ? 2'b10 : 2'b00);
    assign fwd_b = w_ex_hit_b ? 2'b01 : (w_mem_hit_b ? 2'b10 : 2'b00);
`else
    assign w_hz_stall = id_valid && (w_lu_hit || w_ex_hit_a || w_ex_hit_b ||
                                     w_mem_hit_a || w_mem_hit_b);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign w_md_stall = (r_state == S_BUSY);
    assign stall      = w_md_stall || w_hz_stall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ex_rwe    <= 1'b0;
            r_ex_rdst   <= 1'b0;
            r_ex_aluinb <= 1'b0;
            r_ex_dmwe   <= 1'b0;
            r_ex_rwd    <= 1'b0;
            r_ex_aluop  <= '0;
            r_ex_rd     <= '0;
            r_mem_rwe   <= 1'b0;
            r_mem_dmwe  <= 1'b0;
            r_mem_rwd   <= 1'b0;
            r_mem_rd    <= '0;
            r_wb_rwe    <= 1'b0;
            r_wb_rwd    <= 1'b0;
            r_wb_rd     <= '0;
        end else begin
            r_wb_rwe <= r_mem_rwe;
            r_wb_rwd <= r_mem_rwd;
            r_wb_rd  <= r_mem_rd;
            if (w_md_stall) begin
                // EX holds the mul/div; a bubble drains into MEM behind it.
                r_mem_rwe  <= 1'b0;
                r_mem_dmwe <= 1'b0;
                r_mem_rwd  <= 1'b0;
                r_mem_rd   <= '0;
            end else begin
                r_mem_rwe  <= r_ex_rwe;
                r_mem_dmwe <= r_ex_dmwe;
                r_mem_rwd  <= r_ex_rwd;
                r_mem_rd   <= r_ex_rd;
                if (w_hz_stall || !w_id_live) begin
                    r_ex_rwe    <= 1'b0;
                    r_ex_rdst   <= 1'b0;
                    r_ex_aluinb <= 1'b0;
                    r_ex_dmwe   <= 1'b0;
                    r_ex_rwd    <= 1'b0;
                    r_ex_aluop  <= '0;
                    r_ex_rd     <= '0;
                end else begin
                    r_ex_rwe    <= w_dec_rwe && (id_rd != '0);
                    r_ex_rdst   <= w_dec_rdst;
                    r_ex_aluinb <= w_dec_aluinb;
                    r_ex_dmwe   <= w_dec_dmwe;
                    r_ex_rwd    <= w_dec_rwd;
                    r_ex_aluop  <= w_dec_aluop;
                    r_ex_rd     <= id_rd;
                end
            end
        end
    end

    // BUSY is entered on the same edge the mul/div is loaded into EX.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_DONE;
                        r_md_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_IDLE, S_DONE: begin
                    if (w_id_md && !w_hz_stall) begin
                        r_state   <= S_BUSY;
                        r_cnt     <= CNT_W'(MD_LAT - 2);
                        r_md_busy <= 1'b1;
                        r_md_done <= 1'b0;
                    end else begin
                        r_state   <= S_IDLE;
                        r_md_busy <= 1'b0;
                        r_md_done <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_md_busy <= 1'b0;
                    r_md_done <= 1'b0;
                end
            endcase
        end
    end

    assign ex_rwe     = r_ex_rwe;
    assign ex_rdst    = r_ex_rdst;
    assign ex_aluinb  = r_ex_aluinb;
    assign ex_dmwe    = r_ex_dmwe;
    assign ex_rwd     = r_ex_rwd;
    assign ex_aluop   = r_ex_aluop;
    assign ex_md_busy = r_md_busy;
    assign ex_md_done = r_md_done;
    assign mem_dmwe   = r_mem_dmwe;
    assign mem_rwd    = r_mem_rwd;
    assign wb_rwe     = r_wb_rwe;
    assign wb_rwd     = r_wb_rwd;
    assign wb_rd      = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// Testbench for control_pipe: directed scenarios plus a randomized run
// against an instruction-level reference model.
module tb_control_pipe;
    localparam int MD_LAT = 4;
`ifdef CONTROL_PIPE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [4:0] OP_R = 5'd0, OP_ADDI = 5'd5, OP_SW = 5'd7, OP_LW = 5'd8;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       id_valid;
    logic [4:0] id_opcode, id_func, id_rd, id_rs, id_rt;
    logic       stall, illegal, ex_rwe, ex_rdst, ex_aluinb, ex_dmwe, ex_rwd;
    logic [4:0] ex_aluop;
    logic       ex_md_busy, ex_md_done, mem_dmwe, mem_rwd, wb_rwe, wb_rwd;
    logic [4:0] wb_rd;
    logic [1:0] fwd_a, fwd_b;
    logic [26:0] obs;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       rwe, rdst, aluinb, dmwe, rwd;
        logic [4:0] aluop, rd;
        logic       md;
    } ins_t;
    ins_t m_ex, m_mem, m_wb;
    int   m_age;

    control_pipe #(.OP_W(5), .FUNC_W(5), .REG_W(5), .MD_LAT(MD_LAT)) dut (
        .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_func(id_func), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .stall(stall), .illegal(illegal), .ex_rwe(ex_rwe), .ex_rdst(ex_rdst),
        .ex_aluinb(ex_aluinb), .ex_dmwe(ex_dmwe), .ex_rwd(ex_rwd), .ex_aluop(ex_aluop),
        .ex_md_busy(ex_md_busy), .ex_md_done(ex_md_done), .mem_dmwe(mem_dmwe),
        .mem_rwd(mem_rwd), .wb_rwe(wb_rwe), .wb_rwd(wb_rwd), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    assign obs = {stall, illegal, ex_rwe, ex_rdst, ex_aluinb, ex_dmwe, ex_rwd, ex_aluop,
                  ex_md_busy, ex_md_done, mem_dmwe, mem_rwd, wb_rwe, wb_rwd, wb_rd,
                  fwd_a, fwd_b};

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic v, input logic [4:0] op, input logic [4:0] fn,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        id_valid = v; id_opcode = op; id_func = fn; id_rd = rd; id_rs = rs; id_rt = rt;
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        nop();
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Spec decode table, producing the control word an instruction carries down the pipe.
    function automatic ins_t decode(input logic v, input logic [4:0] op, input logic [4:0] fn,
                                    input logic [4:0] rd, output bit ill);
        ins_t d;
        d = '0;
        ill = 1'b0;
        if (v) begin
            case (op)
                OP_R: if (fn <= 5'd7) begin
                          d.rwe = 1'b1; d.aluop = fn; d.md = (fn == 5'd6) || (fn == 5'd7);
                      end else ill = 1'b1;
                OP_ADDI: begin d.rwe = 1'b1; d.aluinb = 1'b1; end
                OP_SW:   begin d.dmwe = 1'b1; d.rdst = 1'b1; d.aluinb = 1'b1; end
                OP_LW:   begin d.rwe = 1'b1; d.rwd = 1'b1; d.aluinb = 1'b1; end
                default: ill = 1'b1;
            endcase
            if (!ill) begin
                d.rd = rd;
                if (rd == 5'd0) d.rwe = 1'b0;
            end
        end
        return d;
    endfunction

    function automatic bit writes(input ins_t s, input logic [4:0] r);
        return s.rwe && r != 5'd0 && s.rd == r;
    endfunction

    task automatic test_reset();
        int acts;
        do_reset();
        issue(1'b1, OP_R, 5'd6, 5'd7, 5'd1, 5'd2);
        next_cycle();
        nop();
        next_cycle();
        chk("reset_pre_busy", 32'(ex_md_busy), 32'd1);
        #2;
        resetn = 1'b0;
        issue(1'b1, 5'h1f, 5'd0, 5'd9, 5'd1, 5'd2);
        #1;
        chk("reset_async_outputs", 32'(obs), 32'd0);
        @(posedge clock);
        #1;
        chk("reset_hold_outputs", 32'(obs), 32'd0);
        nop();
        resetn = 1'b1;
        acts = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (ex_md_busy || ex_md_done || stall) acts++;
            next_cycle();
        end
        chk("reset_no_md_after", 32'(acts), 32'd0);
    endtask

    task automatic test_raw();
        int ns;
        do_reset();
        issue(1'b1, OP_ADDI, 5'd0, 5'd3, 5'd1, 5'd0);
        @(negedge clock);
        chk("raw_addi_nostall", 32'(stall), 32'd0);
        next_cycle();
        issue(1'b1, OP_R, 5'd0, 5'd4, 5'd3, 5'd3);
        @(negedge clock);
        chk("raw_fwd_a", 32'(fwd_a), BYP ? 32'd1 : 32'd0);
        chk("raw_fwd_b", 32'(fwd_b), BYP ? 32'd1 : 32'd0);
        ns = 0;
        for (int i = 0; i < 8 && stall === 1'b1; i++) begin
            ns++;
            next_cycle();
            @(negedge clock);
        end
        chk("raw_stall_cycles", 32'(ns), BYP ? 32'd0 : 32'd2);
        next_cycle();
        nop();
        @(negedge clock);
        chk("raw_add_in_ex", 32'({ex_rwe, ex_aluinb, ex_aluop}), 32'b1_0_00000);
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1'b1, OP_LW, 5'd0, 5'd5, 5'd1, 5'd0);
        @(negedge clock);
        next_cycle();
        issue(1'b1, OP_R, 5'd1, 5'd6, 5'd5, 5'd1);
        @(negedge clock);
        chk("lu_stall_first", 32'(stall), 32'd1);
        next_cycle();
        @(negedge clock);
        chk("lu_ex_bubble", 32'({ex_rwe, ex_rwd}), 32'd0);
        chk("lu_stall_second", 32'(stall), BYP ? 32'd0 : 32'd1);
        chk("lu_fwd", 32'({fwd_a, fwd_b}), BYP ? 32'b10_00 : 32'd0);
        if (!BYP) begin
            next_cycle();
            @(negedge clock);
            chk("lu_stall_release", 32'(stall), 32'd0);
        end
        next_cycle();
        nop();
        @(negedge clock);
        chk("lu_sub_in_ex", 32'({ex_rwe, ex_aluop}), 32'b1_00001);
    endtask

    task automatic test_muldiv();
        logic [8:0] sv, dv, bv, wv;
        logic [4:0] op4;
        do_reset();
        op4 = '0;
        for (int c = 0; c <= 8; c++) begin
            if (c == 0) issue(1'b1, OP_R, 5'd6, 5'd7, 5'd1, 5'd2);
            if (c == 1) nop();
            @(negedge clock);
            sv[c] = stall; dv[c] = ex_md_done; bv[c] = ex_md_busy; wv[c] = wb_rwe;
            if (c == 4) op4 = ex_aluop;
            next_cycle();
        end
        chk("mul_stall_window", 32'(sv), 32'b0_0000_1110);
        chk("mul_done_pulse",   32'(dv), 32'b0_0001_0000);
        chk("mul_busy_window",  32'(bv), 32'b0_0001_1110);
        chk("mul_wb_rwe",       32'(wv), 32'b0_0100_0000);
        chk("mul_aluop_done",   32'(op4), 32'd6);
    endtask

    task automatic test_back_to_back();
        logic [11:0] sv, dv, wv;
        logic [4:0]  rd10;
        do_reset();
        rd10 = '0;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) issue(1'b1, OP_R, 5'd6, 5'd7, 5'd1, 5'd2);
            if (c == 1) issue(1'b1, OP_R, 5'd7, 5'd8, 5'd1, 5'd2);
            if (c == 5) nop();
            @(negedge clock);
            sv[c] = stall; dv[c] = ex_md_done; wv[c] = wb_rwe;
            if (c == 10) rd10 = wb_rd;
            next_cycle();
        end
        chk("b2b_stall_windows", 32'(sv), 32'b0000_1110_1110);
        chk("b2b_done_pulses",   32'(dv), 32'b0001_0001_0000);
        chk("b2b_wb_rwe",        32'(wv), 32'b0100_0100_0000);
        chk("b2b_div_wb_rd",     32'(rd10), 32'd8);
    endtask

    task automatic test_illegal();
        do_reset();
        issue(1'b1, 5'h1f, 5'd0, 5'd9, 5'd1, 5'd2);
        @(negedge clock);
        chk("ill_op_flag", 32'({illegal, stall}), 32'b10);
        next_cycle();
        issue(1'b1, OP_R, 5'b01010, 5'd10, 5'd1, 5'd2);
        @(negedge clock);
        chk("ill_func_flag", 32'({illegal, stall}), 32'b10);
        chk("ill_op_ex_bubble", 32'(ex_rwe), 32'd0);
        next_cycle();
        issue(1'b1, OP_ADDI, 5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clock);
        chk("legal_addi_flag", 32'(illegal), 32'd0);
        chk("ill_func_ex_bubble", 32'(ex_rwe), 32'd0);
        next_cycle();
        nop();
        @(negedge clock);
        chk("ill_op_wb", 32'(wb_rwe), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("ill_func_wb", 32'(wb_rwe), 32'd0);
        next_cycle();
        issue(1'b1, OP_LW, 5'd0, 5'd0, 5'd1, 5'd0);
        @(negedge clock);
        chk("lw_r0_nostall", 32'(stall), 32'd0);
        next_cycle();
        issue(1'b1, OP_R, 5'd0, 5'd1, 5'd0, 5'd0);
        @(negedge clock);
        chk("use_r0_nostall", 32'(stall), 32'd0);
        next_cycle();
        nop();
    endtask

    task automatic test_random();
        logic       v;
        logic [4:0] op, fn, rd, rs, rt;
        ins_t       d;
        bit         ill, mds, lu, hz, st, held;
        logic [1:0] fa, fb;
        logic [26:0] exp;
        int k;
        do_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_age = 0;
        held = 1'b0;
        v = 1'b0; op = '0; fn = '0; rd = '0; rs = '0; rt = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!held) begin
                v  = ($urandom_range(0, 9) != 0);
                k  = int'($urandom_range(0, 9));
                fn = 5'($urandom_range(0, 31));
                rd = 5'($urandom_range(0, 3));
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
                if (k <= 4) begin op = OP_R; fn = 5'($urandom_range(0, 7)); end
                else if (k == 5) op = OP_ADDI;
                else if (k == 6) op = OP_SW;
                else if (k <= 8) op = OP_LW;
                else if ($urandom_range(0, 1) == 0) op = 5'($urandom_range(9, 31));
                else begin op = OP_R; fn = 5'($urandom_range(8, 31)); end
            end
            issue(v, op, fn, rd, rs, rt);
            d   = decode(v, op, fn, rd, ill);
            mds = m_ex.md && (m_age < MD_LAT);
            lu  = v && m_ex.rwd && m_ex.rd != 5'd0 && (m_ex.rd == rs || m_ex.rd == rt);
            if (BYP) begin
                hz = lu;
                fa = writes(m_ex, rs) ? 2'b01 : (writes(m_mem, rs) ? 2'b10 : 2'b00);
                fb = writes(m_ex, rt) ? 2'b01 : (writes(m_mem, rt) ? 2'b10 : 2'b00);
            end else begin
                hz = lu || (v && (writes(m_ex, rs) || writes(m_ex, rt) ||
                                  writes(m_mem, rs) || writes(m_mem, rt)));
                fa = 2'b00;
                fb = 2'b00;
            end
            st  = mds || hz;
            exp = {st, ill, m_ex.rwe, m_ex.rdst, m_ex.aluinb, m_ex.dmwe, m_ex.rwd, m_ex.aluop,
                   m_ex.md, m_ex.md && (m_age == MD_LAT), m_mem.dmwe, m_mem.rwd,
                   m_wb.rwe, m_wb.rwd, m_wb.rd, fa, fb};
            @(negedge clock);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got %h, expected %h", cyc, obs, exp);
            end
            m_wb = m_mem;
            if (mds) begin
                m_mem = '0;
                m_age++;
            end else begin
                m_mem = m_ex;
                m_ex  = hz ? ins_t'('0) : d;
                m_age = 1;
            end
            held = st;
            next_cycle();
        end
    endtask

    initial begin
        nop();
        test_reset();
        test_raw();
        test_load_use();
        test_muldiv();
        test_back_to_back();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
